// File: rtl/mem_loader_pkg.sv
// Shared constants for the switch/button memory loader: FSM encodings,
// region codes and the default debounce length.
package mem_loader_pkg;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam logic [1:0] CAP_HI = 2'd0;
  localparam logic [1:0] CAP_LO = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] FULL   = 2'd3;

  localparam logic REGION_INSTR = 1'b0;
  localparam logic REGION_DATA  = 1'b1;
endpackage

// File: rtl/mem_loader_if.sv
// Memory write port driven by the loader, plus the FSM state for observation.
// Strobe semantics: wr_en is high for exactly one cycle and there is no ready;
// wr_region/wr_addr/wr_data are registered and stable for that whole cycle.
interface mem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              wr_en;
  logic              wr_region;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [1:0]        state;

  modport master (output wr_en, output wr_region, output wr_addr, output wr_data, output state);
  modport slave  (input  wr_en, input  wr_region, input  wr_addr, input  wr_data, input  state);
endinterface

// File: rtl/mem_loader_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on the first cycle the debounced level is high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // The flip lands on the edge where the disagreement count would reach
  // DEBOUNCE_CYCLES, so the counter compares against one less.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;
endmodule

// File: rtl/mem_loader.sv
// Assembles 32-bit words from two switch halfwords (upper first) and writes
// them with an auto-incrementing address into the selected memory region.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ADDR_W          = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        sw,
  input  logic               btn_load,
  input  logic               btn_region,
  input  logic               btn_rewind,
  output logic [15:0]        led,
  output logic               hi_pending,
  output logic               full,
  mem_loader_if.master       bus
);
  logic        load_press;
  logic        region_press;
  logic        rewind_press;
  logic        load_ev;
  logic        region_ev;
  logic [1:0]  state;
  logic [15:0] hi_reg;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .reset(reset), .raw(btn_load), .press(load_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_region (
    .clk(clk), .reset(reset), .raw(btn_region), .press(region_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rewind (
    .clk(clk), .reset(reset), .raw(btn_rewind), .press(rewind_press));

  // Priority: rewind > region > load; losers in the same cycle are dropped.
  assign region_ev = region_press & ~rewind_press;
  assign load_ev   = load_press & ~rewind_press & ~region_press;

  // A region/rewind during WRITE is safe to apply at once: the strobe cycle
  // has already presented the old region/address by the time this edge hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CAP_HI;
      hi_reg        <= '0;
      led           <= '0;
      hi_pending    <= 1'b0;
      full          <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_region <= REGION_INSTR;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (rewind_press || region_ev) begin
        if (region_ev) begin
          bus.wr_region <= (bus.wr_region == REGION_INSTR) ? REGION_DATA : REGION_INSTR;
        end
        bus.wr_addr <= '0;
        full        <= 1'b0;
        hi_pending  <= 1'b0;
        state       <= CAP_HI;
      end else begin
        case (state)
          CAP_HI: if (load_ev) begin
            hi_reg     <= sw;
            led        <= sw;
            hi_pending <= 1'b1;
            state      <= CAP_LO;
          end
          CAP_LO: if (load_ev) begin
            bus.wr_data <= {hi_reg, sw};
            led         <= sw;
            hi_pending  <= 1'b0;
            bus.wr_en   <= 1'b1;
            state       <= WRITE;
          end
          WRITE: begin
            if (bus.wr_addr == {ADDR_W{1'b1}}) begin
              full  <= 1'b1;
              state <= FULL;
            end else begin
              bus.wr_addr <= bus.wr_addr + 1'b1;
              state       <= CAP_HI;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.state = state;
endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a short debounce; every write strobe is
// matched against an expected queue of {region, addr, data}.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int DB     = 4;
  localparam int ADDR_W = 7;
  localparam int HOLD   = DB + 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = '0;
  logic        btn_load = 1'b0;
  logic        btn_region = 1'b0;
  logic        btn_rewind = 1'b0;
  logic [15:0] led;
  logic        hi_pending;
  logic        full;

  mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mem_loader #(.DEBOUNCE_CYCLES(DB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load),
    .btn_region(btn_region), .btn_rewind(btn_rewind),
    .led(led), .hi_pending(hi_pending), .full(full), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int pushed = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) check("unexpected_write", {24'd0, bus.wr_region, bus.wr_addr, bus.wr_data}, 64'd0);
      else check("write", {24'd0, bus.wr_region, bus.wr_addr, bus.wr_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // drivers
  task automatic press(input logic ld, input logic rg, input logic rw);
    @(negedge clk);
    btn_load = ld; btn_region = rg; btn_rewind = rw;
    repeat (HOLD) @(negedge clk);
    btn_load = 1'b0; btn_region = 1'b0; btn_rewind = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] hi, input logic [15:0] lo,
                           input logic rg, input logic [ADDR_W-1:0] addr);
    exp_q.push_back({rg, addr, hi, lo});
    pushed++;
    sw = hi; press(1'b1, 1'b0, 1'b0);
    sw = lo; press(1'b1, 1'b0, 1'b0);
  endtask

  logic [15:0] hi_w;
  logic [15:0] lo_w;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_region", bus.wr_region, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_data", bus.wr_data, 0);
    check("rst_led", led, 0);
    check("rst_hi_pending", hi_pending, 0);
    check("rst_full", full, 0);
    check("rst_state", bus.state, CAP_HI);

    // one word
    load_word(16'hE59F, 16'h11F8, 1'b0, 7'd0);
    check("w1_addr", bus.wr_addr, 1);
    check("w1_led", led, 16'h11F8);
    check("w1_hi_pending", hi_pending, 0);
    check("w1_data_held", bus.wr_data, 32'hE59F11F8);

    // bounce rejection: 2-high/2-low chatter, then a solid press
    sw = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_load = (i % 4) < 2;
    end
    @(negedge clk); btn_load = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_load = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("bounce_hi_pending", hi_pending, 1);
    check("bounce_led", led, 16'h1234);
    check("bounce_state", bus.state, CAP_LO);
    exp_q.push_back({1'b0, 7'd1, 32'h12345678});
    pushed++;
    sw = 16'h5678; press(1'b1, 1'b0, 1'b0);
    load_word(16'hA5A5, 16'h5A5A, 1'b0, 7'd2);
    check("instr3_addr", bus.wr_addr, 3);

    // region switch and data write
    press(1'b0, 1'b1, 1'b0);
    check("region_sel", bus.wr_region, 1);
    check("region_addr", bus.wr_addr, 0);
    load_word(16'h0000, 16'h0C00, 1'b1, 7'd0);
    check("data_addr", bus.wr_addr, 1);

    // rewind discards a half-built word
    sw = 16'hFFFF; press(1'b1, 1'b0, 1'b0);
    check("pre_rewind_hi_pending", hi_pending, 1);
    press(1'b0, 1'b0, 1'b1);
    check("rewind_hi_pending", hi_pending, 0);
    check("rewind_addr", bus.wr_addr, 0);
    check("rewind_region", bus.wr_region, 1);
    check("rewind_state", bus.state, CAP_HI);

    // fill the data region
    for (int i = 0; i < 128; i++) begin
      hi_w = 16'(i);
      lo_w = 16'(i) ^ 16'h5555;
      load_word(hi_w, lo_w, 1'b1, 7'(i));
    end
    check("full_flag", full, 1);
    check("full_addr", bus.wr_addr, 127);
    check("full_state", bus.state, FULL);
    sw = 16'h9999;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("full_still", full, 1);
    check("full_led", led, lo_w);
    check("full_hi_pending", hi_pending, 0);
    press(1'b0, 1'b0, 1'b1);
    check("unfull_flag", full, 0);
    check("unfull_addr", bus.wr_addr, 0);

    // simultaneous events: rewind beats load, region beats load
    sw = 16'hBEEF;
    press(1'b1, 1'b0, 1'b1);
    check("sim_rw_hi_pending", hi_pending, 0);
    check("sim_rw_addr", bus.wr_addr, 0);
    check("sim_rw_state", bus.state, CAP_HI);
    check("sim_rw_led", led, lo_w);
    press(1'b1, 1'b1, 1'b0);
    check("sim_rg_region", bus.wr_region, 0);
    check("sim_rg_hi_pending", hi_pending, 0);
    check("sim_rg_led", led, lo_w);

    // reset mid-word
    sw = 16'hABCD; press(1'b1, 1'b0, 1'b0);
    check("mid_hi_pending", hi_pending, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_led", led, 0);
    check("mid_rst_hi_pending", hi_pending, 0);
    check("mid_rst_state", bus.state, CAP_HI);
    check("mid_rst_addr", bus.wr_addr, 0);
    check("mid_rst_data", bus.wr_data, 0);
    check("mid_rst_region", bus.wr_region, 0);
    load_word(16'h1111, 16'h2222, 1'b0, 7'd0);
    check("fresh_addr", bus.wr_addr, 1);

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("write_count", wr_count, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
Switch/button front-end that writes 32-bit words into the board's instruction and data memories.
- Operator sets the 16 slide switches and presses LOAD. Two presses make one word: upper halfword first, then lower halfword.
- The block issues a one-cycle write strobe with an auto-incrementing address.
- It is the write-side counterpart of the LED memory-dump display and uses the same halfword order and region split.
- Sits between board I/O (switches, buttons, LEDs) and the memory write ports.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz).
- ADDR_W, 7: word address width; memory depth is 2**ADDR_W (128).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sw  in  16  halfword value from slide switches
- btn_load  in  1  raw LOAD button (asynchronous, bouncy)
- btn_region  in  1  raw button; toggles target region
- btn_rewind  in  1  raw button; restarts at address 0
- wr_en  out  1  one-cycle write strobe
- wr_region  out  1  0 = instruction memory, 1 = data memory
- wr_addr  out  ADDR_W  word address for the current write
- wr_data  out  32  {upper halfword, lower halfword}
- led  out  16  last captured halfword
- hi_pending  out  1  upper halfword captured, lower halfword awaited
- full  out  1  region filled; LOAD ignored

Behaviour:
- Reset values: wr_en 0, wr_region 0, wr_addr 0, wr_data 0, led 0, hi_pending 0, full 0, state CAP_HI, all debounce counters 0, all debounced levels 0.
- Reset asserted mid-operation discards any partial word and suppresses any pending strobe in the next cycle.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Counter increments each cycle the synchronized value differs from the debounced level, and clears on any agreement.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse in the first cycle the debounced level is 1. Release generates no event.
- Latency: raw press first sampled at edge 0 → debounced high after edge DEBOUNCE_CYCLES+1 → capture at edge DEBOUNCE_CYCLES+2.
- FSM states:
  - CAP_HI, on load event: hi_reg <= sw; led <= sw; hi_pending <= 1; go to CAP_LO.
  - CAP_LO, on load event: wr_data <= {hi_reg, sw}; led <= sw; hi_pending <= 0; go to WRITE.
  - WRITE (exactly one cycle): wr_en = 1 while wr_addr and wr_region hold the target.
    - Leaving WRITE with wr_addr < max: wr_addr increments, go to CAP_HI.
    - Leaving WRITE with wr_addr = 2**ADDR_W-1: wr_addr holds, full <= 1, go to FULL.
  - FULL: load events ignored; wr_en stays 0.
- wr_en, wr_data, wr_addr and wr_region are registered and stable throughout the strobe cycle. wr_data holds its value after the strobe.
- Load events arriving during WRITE are dropped.
- Region event, from any state: wr_region toggles; wr_addr <= 0; full <= 0; hi_pending <= 0; go to CAP_HI.
  - In WRITE, the pending strobe still completes at the old region/address first, then the toggle applies.
- Rewind event: same as region event, without toggling wr_region.
- Simultaneous events in one cycle: rewind > region > load. Lower-priority events in that cycle are discarded.
- No address wrap-around: 128 words per region, then FULL.

Decomposition:
- Shared package mem_loader_pkg:
  - FSM state enum {CAP_HI, CAP_LO, WRITE, FULL}.
  - Region constants REGION_INSTR = 0, REGION_DATA = 1.
  - Default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (synchronizer + counter + press pulse), instantiated three times.

Test Plan:
- DEBOUNCE_CYCLES = 4 throughout.
- Load one word: reset; sw = 16'hE59F, press LOAD; sw = 16'h11F8, press LOAD → single wr_en pulse with wr_region 0, wr_addr 0, wr_data 32'hE59F11F8. Then wr_addr = 1, led = 16'h11F8, hi_pending 0.
- Bounce rejection: LOAD toggles 1/0 every 2 cycles for 20 cycles, then stays high → exactly one capture; hi_pending 1; led equals sw.
- Region and rewind: after 3 instruction writes, press REGION → wr_region 1, wr_addr 0. Load 16'h0000 / 16'h0C00 → write to data address 0 of 32'h00000C00. Press REWIND while hi_pending = 1 → hi_pending 0, partial word discarded, no write.
- Full region: 128 word loads → last write at wr_addr 127, full 1. Further LOAD presses produce no wr_en. REWIND clears full and sets wr_addr 0.
- Simultaneous events: REWIND and LOAD debounced in the same cycle → no capture, wr_addr 0, state CAP_HI.
- Reset mid-word: capture upper 16'hABCD, assert reset one cycle → all outputs back to reset values. The next two loads form a fresh word at address 0 with no stale upper halfword.
